regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised integer register file with a per-register scoreboard for the pipelined core. It provides configurable word width and register count, two combinational read ports and one write-back port. Write-first bypass forwards same-cycle write-back data to the read ports. A busy-bit scoreboard tracks registers with writes in flight and generates the decode-stage hazard/stall signal. Register 0 is hard-wired to zero.

Parameters:
XLEN, 32, data word width in bits
NREGS, 32, number of architectural registers; power of two, at least 2
AW, log2(NREGS), register address width; derived, do not override

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
rs1_addr  input  AW  read port 1 address
rs1_used  input  1  the decoding instruction consumes rs1
rs1_data  output  XLEN  read port 1 data
rs2_addr  input  AW  read port 2 address
rs2_used  input  1  the decoding instruction consumes rs2
rs2_data  output  XLEN  read port 2 data
wb_en  input  1  write-back strobe
wb_addr  input  AW  write-back destination
wb_data  input  XLEN  write-back data
iss_en  input  1  instruction issued this cycle; already gated by !stall upstream
iss_rd  input  AW  destination register of the issued instruction
stall  output  1  RAW hazard on a used source operand
busy_vec  output  NREGS  scoreboard bits; bit i set means register i has a write in flight
busy_cnt  output  AW+1  population count of busy_vec, registered

Behaviour:
- Reset is asynchronous and active-high. It forces every register to 0, busy_vec to 0 and busy_cnt to 0. rs*_data read 0 while rst is high. Reset during any operation discards all pending writes and busy bits, with no partial update.
- Register write: on the clk rising edge, if wb_en is high and wb_addr is not 0, then regs[wb_addr] takes wb_data. A write to address 0 is ignored.
- Reads are combinational with zero latency.
  - rsN_data = 0 if rsN_addr is 0.
  - Otherwise rsN_data = wb_data if wb_en is high and wb_addr equals rsN_addr (write-first bypass).
  - Otherwise rsN_data = regs[rsN_addr].
- Scoreboard set: on the clk rising edge, if iss_en is high and iss_rd is not 0, then busy[iss_rd] is set to 1.
- Scoreboard clear: on the clk rising edge, if wb_en is high and wb_addr is not 0, then busy[wb_addr] is cleared to 0.
- Simultaneous set and clear of the same register: the set wins and the bit stays 1. This covers a new producer issuing while an older one writes back.
- Set and clear of different registers in the same cycle: both take effect.
- busy[0] is always 0.
- Effective busy, combinational: ebusyN = busy[rsN_addr] AND NOT (wb_en AND wb_addr == rsN_addr). The bypass covers the write-back cycle.
- stall = (rs1_used AND ebusy1) OR (rs2_used AND ebusy2). Combinational, no registered delay.
- busy_cnt always equals popcount(busy_vec) after each edge. It is updated as a registered next-state count: +1 for a set of a non-busy register, -1 for a clear without a set, net 0 otherwise. Range is 0 to NREGS-1, with no wrap.
- wb_en to a register that is not busy is legal. The data is written, the busy bit stays 0 and the count is unchanged.
- The block has a single write port. Callers serialise write-back.

Test Plan:
1. Reset and x0: assert rst mid-run with regs[5]=0xDEADBEEF and busy[5]=1. Required: rs1_data=0 and busy_vec=0 immediately, without waiting for a clock edge. Then wb_en, addr 0, data 0x1234. Required: rs1_addr=0 reads 0 and busy_vec[0]=0.
2. Write/read and bypass: write 0xA5A5A5A5 to r7, then read r7. Required: 0xA5A5A5A5. Then, in the same cycle as wb_en to r7 with 0x11111111, read r7 on both ports. Required: both ports return 0x11111111 before the edge.
3. RAW stall: issue rd=3, next cycle rs1_addr=3 with rs1_used=1. Required: stall=1. Set rs1_used=0. Required: stall=0. Write back r3 with 0x42. Required: stall=0 in the write-back cycle, rs1_data=0x42, and busy_vec[3]=0 after the edge.
4. Set/clear collision: busy[9]=1, then in the same cycle iss_en with rd=9 and wb_en with addr 9, data 0x77. Required: regs[9]=0x77, busy[9] stays 1, busy_cnt unchanged.
5. Count: issue r1..r31 over consecutive cycles. Required: busy_cnt=31. Issue rd=0. Required: no change. Write back all 31 in reverse order. Required: busy_cnt counts down to 0 with no underflow; an extra wb to an idle r4 leaves the count at 0.
6. Parameter sweep: XLEN=64 and NREGS=16. Repeat scenarios 2 and 3 with 0xFEDCBA9876543210 on r15. Required: correct data and stall behaviour.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - integer register file with write-first bypass and busy-bit scoreboard
// Register 0 reads as zero and never becomes busy; stall covers RAW hazards on used sources.
module regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    rs1_addr,
  input  logic             rs1_used,
  output logic [XLEN-1:0]  rs1_data,
  input  logic [AW-1:0]    rs2_addr,
  input  logic             rs2_used,
  output logic [XLEN-1:0]  rs2_data,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_rd,
  output logic             stall,
  output logic [NREGS-1:0] busy_vec,
  output logic [AW:0]      busy_cnt
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             wb_act, iss_act, set_new, clr_real;
  logic             ebusy1, ebusy2;

  assign wb_act  = wb_en && (wb_addr != '0);
  assign iss_act = iss_en && (iss_rd != '0);

  always_comb begin
    regs_d = regs_q;
    if (wb_act) regs_d[wb_addr] = wb_data;
  end

  // A set of the register being written back wins, so that clear never counts.
  always_comb begin
    busy_d = busy_q;
    if (wb_act)  busy_d[wb_addr] = 1'b0;
    if (iss_act) busy_d[iss_rd]  = 1'b1;
    busy_d[0] = 1'b0;
    set_new  = iss_act && !busy_q[iss_rd];
    clr_real = wb_act && busy_q[wb_addr] && !(iss_act && (iss_rd == wb_addr));
    cnt_d    = cnt_q + {{AW{1'b0}}, set_new} - {{AW{1'b0}}, clr_real};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (!rst && (rs1_addr != '0)) begin
      if (wb_en && (wb_addr == rs1_addr)) rs1_data = wb_data;
      else                                rs1_data = regs_q[rs1_addr];
    end
  end

  always_comb begin
    rs2_data = '0;
    if (!rst && (rs2_addr != '0)) begin
      if (wb_en && (wb_addr == rs2_addr)) rs2_data = wb_data;
      else                                rs2_data = regs_q[rs2_addr];
    end
  end

  // The write-back cycle forwards data, so a busy source being written is not a hazard.
  assign ebusy1 = busy_q[rs1_addr] && !(wb_en && (wb_addr == rs1_addr));
  assign ebusy2 = busy_q[rs2_addr] && !(wb_en && (wb_addr == rs2_addr));
  assign stall  = (rs1_used && ebusy1) || (rs2_used && ebusy2);

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb (32x32 and 16x64 instances)
module tb_regfile_sb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0]  a_rs1, a_rs2, a_wba, a_iss;
  logic        a_u1, a_u2, a_wbe, a_isse, a_stall;
  logic [31:0] a_wbd, a_r1, a_r2, a_busy;
  logic [5:0]  a_cnt;

  logic [3:0]  b_rs1, b_rs2, b_wba, b_iss;
  logic        b_u1, b_u2, b_wbe, b_isse, b_stall;
  logic [63:0] b_wbd, b_r1, b_r2;
  logic [15:0] b_busy;
  logic [4:0]  b_cnt;

  int pass_cnt = 0;
  int total    = 0;

  regfile_sb d32 (
    .clk(clk), .rst(rst),
    .rs1_addr(a_rs1), .rs1_used(a_u1), .rs1_data(a_r1),
    .rs2_addr(a_rs2), .rs2_used(a_u2), .rs2_data(a_r2),
    .wb_en(a_wbe), .wb_addr(a_wba), .wb_data(a_wbd),
    .iss_en(a_isse), .iss_rd(a_iss),
    .stall(a_stall), .busy_vec(a_busy), .busy_cnt(a_cnt)
  );

  regfile_sb #(.XLEN(64), .NREGS(16)) d64 (
    .clk(clk), .rst(rst),
    .rs1_addr(b_rs1), .rs1_used(b_u1), .rs1_data(b_r1),
    .rs2_addr(b_rs2), .rs2_used(b_u2), .rs2_data(b_r2),
    .wb_en(b_wbe), .wb_addr(b_wba), .wb_data(b_wbd),
    .iss_en(b_isse), .iss_rd(b_iss),
    .stall(b_stall), .busy_vec(b_busy), .busy_cnt(b_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    a_rs1 = '0; a_rs2 = '0; a_wba = '0; a_iss = '0;
    a_u1 = 1'b0; a_u2 = 1'b0; a_wbe = 1'b0; a_isse = 1'b0; a_wbd = '0;
    b_rs1 = '0; b_rs2 = '0; b_wba = '0; b_iss = '0;
    b_u1 = 1'b0; b_u2 = 1'b0; b_wbe = 1'b0; b_isse = 1'b0; b_wbd = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    check("reset_busy", 64'(a_busy), 64'h0);
    check("reset_cnt", 64'(a_cnt), 64'h0);
    check("reset_rd", 64'(a_r1), 64'h0);

    // 1: load r5 while issuing it, then reset mid-cycle
    a_wbe = 1'b1; a_wba = 5'd5; a_wbd = 32'hDEADBEEF; a_isse = 1'b1; a_iss = 5'd5;
    step();
    idle();
    a_rs1 = 5'd5;
    #1;
    check("r5_loaded", 64'(a_r1), 64'hDEADBEEF);
    check("r5_busy", 64'(a_busy), 64'h20);
    check("r5_cnt", 64'(a_cnt), 64'h1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_rd", 64'(a_r1), 64'h0);
    check("async_rst_busy", 64'(a_busy), 64'h0);
    check("async_rst_cnt", 64'(a_cnt), 64'h0);
    #1 rst = 1'b0;
    #1;
    check("post_rst_r5", 64'(a_r1), 64'h0);
    a_rs1 = 5'd0; a_wbe = 1'b1; a_wba = 5'd0; a_wbd = 32'h1234;
    #1;
    check("x0_no_bypass", 64'(a_r1), 64'h0);
    step();
    idle();
    check("x0_read", 64'(a_r1), 64'h0);
    check("x0_not_busy", 64'(a_busy[0]), 64'h0);

    // 2: write/read and write-first bypass
    a_wbe = 1'b1; a_wba = 5'd7; a_wbd = 32'hA5A5A5A5;
    step();
    idle();
    a_rs1 = 5'd7;
    #1;
    check("r7_read", 64'(a_r1), 64'hA5A5A5A5);
    a_rs2 = 5'd7; a_wbe = 1'b1; a_wba = 5'd7; a_wbd = 32'h11111111;
    #1;
    check("bypass_rs1", 64'(a_r1), 64'h11111111);
    check("bypass_rs2", 64'(a_r2), 64'h11111111);
    step();
    idle();
    a_rs2 = 5'd7;
    #1;
    check("r7_after_bypass", 64'(a_r2), 64'h11111111);

    // 3: RAW stall on r3
    a_isse = 1'b1; a_iss = 5'd3;
    step();
    idle();
    a_rs1 = 5'd3; a_u1 = 1'b1;
    #1;
    check("stall_raw", 64'(a_stall), 64'h1);
    a_u1 = 1'b0;
    #1;
    check("stall_unused", 64'(a_stall), 64'h0);
    a_rs2 = 5'd3; a_u2 = 1'b1;
    #1;
    check("stall_rs2", 64'(a_stall), 64'h1);
    a_u2 = 1'b0; a_u1 = 1'b1; a_wbe = 1'b1; a_wba = 5'd3; a_wbd = 32'h42;
    #1;
    check("stall_wb_cycle", 64'(a_stall), 64'h0);
    check("r3_bypass", 64'(a_r1), 64'h42);
    step();
    a_wbe = 1'b0;
    #1;
    check("r3_cleared", 64'(a_busy[3]), 64'h0);
    check("r3_no_stall", 64'(a_stall), 64'h0);
    check("r3_read", 64'(a_r1), 64'h42);
    idle();

    // 4: set/clear collision on r9
    a_isse = 1'b1; a_iss = 5'd9;
    step();
    check("r9_cnt", 64'(a_cnt), 64'h1);
    a_wbe = 1'b1; a_wba = 5'd9; a_wbd = 32'h77;
    step();
    idle();
    a_rs1 = 5'd9;
    #1;
    check("coll_data", 64'(a_r1), 64'h77);
    check("coll_busy", 64'(a_busy), 64'h200);
    check("coll_cnt", 64'(a_cnt), 64'h1);
    a_wbe = 1'b1; a_wba = 5'd9; a_wbd = 32'h77;
    step();
    idle();
    check("r9_drain", 64'(a_cnt), 64'h0);

    // set and clear of different registers in one cycle
    a_isse = 1'b1; a_iss = 5'd1;
    step();
    a_iss = 5'd2; a_wbe = 1'b1; a_wba = 5'd1; a_wbd = 32'h5;
    step();
    idle();
    check("diff_busy", 64'(a_busy), 64'h4);
    check("diff_cnt", 64'(a_cnt), 64'h1);
    a_wbe = 1'b1; a_wba = 5'd2;
    step();
    idle();
    check("diff_drain", 64'(a_cnt), 64'h0);

    // 5: fill and drain the scoreboard
    for (int i = 1; i < 32; i++) begin
      a_isse = 1'b1; a_iss = 5'(i);
      step();
    end
    idle();
    check("fill_cnt", 64'(a_cnt), 64'd31);
    check("fill_busy", 64'(a_busy), 64'hFFFFFFFE);
    a_isse = 1'b1; a_iss = 5'd0;
    step();
    idle();
    check("iss_x0_cnt", 64'(a_cnt), 64'd31);
    check("iss_x0_busy", 64'(a_busy), 64'hFFFFFFFE);
    for (int i = 31; i >= 1; i--) begin
      a_wbe = 1'b1; a_wba = 5'(i); a_wbd = 32'(i);
      step();
      check("drain_cnt", 64'(a_cnt), 64'(i - 1));
    end
    a_wbe = 1'b1; a_wba = 5'd4; a_wbd = 32'hCAFE;
    step();
    idle();
    a_rs1 = 5'd4;
    #1;
    check("idle_wb_cnt", 64'(a_cnt), 64'h0);
    check("idle_wb_busy", 64'(a_busy), 64'h0);
    check("idle_wb_data", 64'(a_r1), 64'hCAFE);
    idle();

    // 6: 64-bit, 16-register instance on r15
    b_wbe = 1'b1; b_wba = 4'd15; b_wbd = 64'hFEDCBA9876543210;
    step();
    idle();
    b_rs1 = 4'd15;
    #1;
    check("w64_read", b_r1, 64'hFEDCBA9876543210);
    b_rs2 = 4'd15; b_wbe = 1'b1; b_wba = 4'd15; b_wbd = 64'h0123456789ABCDEF;
    #1;
    check("w64_bypass1", b_r1, 64'h0123456789ABCDEF);
    check("w64_bypass2", b_r2, 64'h0123456789ABCDEF);
    step();
    idle();
    b_isse = 1'b1; b_iss = 4'd15;
    step();
    idle();
    b_rs1 = 4'd15; b_u1 = 1'b1;
    #1;
    check("w64_stall", 64'(b_stall), 64'h1);
    check("w64_cnt", 64'(b_cnt), 64'h1);
    b_u1 = 1'b0;
    #1;
    check("w64_unused", 64'(b_stall), 64'h0);
    b_u1 = 1'b1; b_wbe = 1'b1; b_wba = 4'd15; b_wbd = 64'hFEDCBA9876543210;
    #1;
    check("w64_wb_stall", 64'(b_stall), 64'h0);
    check("w64_wb_data", b_r1, 64'hFEDCBA9876543210);
    step();
    idle();
    check("w64_busy", 64'(b_busy), 64'h0);
    check("w64_cnt_end", 64'(b_cnt), 64'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
